// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: FSM encoding and the
// lab-CPU opcode fields (instr[15:11]) that benches use to build programs.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_KICK    = 3'd2,
    S_WAIT_LO = 3'd3,
    S_WAIT_HI = 3'd4
  } state_e;

  localparam logic [4:0] OP_MOV_IMM = 5'b11010;
  localparam logic [4:0] OP_MOV_SH  = 5'b11000;
  localparam logic [4:0] OP_ADD     = 5'b10100;
  localparam logic [4:0] OP_CMP     = 5'b10101;
  localparam logic [4:0] OP_AND     = 5'b10110;
  localparam logic [4:0] OP_MVN     = 5'b10111;

  // States in which the watchdog runs and the CPU owns the handshake.
  function automatic logic is_wait(input state_e s);
    return (s == S_WAIT_LO) || (s == S_WAIT_HI);
  endfunction

endpackage

// File: rtl/prog_mem.sv
// Program store: DEPTH x 16, synchronous write, asynchronous read, no reset
// so a loaded program survives a sequencer reset.
module prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [15:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Feeds a stored program into the lab CPU one instruction at a time over the
// in/load/s/w handshake, with a per-instruction watchdog on w.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          cpu_w,
  output logic [15:0]   cpu_in,
  output logic          cpu_load,
  output logic          cpu_s,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] pc
);

  localparam int             CW      = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]    DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [CW-1:0]  WD_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [CW-1:0] wd_q, wd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   cin_q, cin_d;

  logic          idle_free;
  logic          mem_we;
  logic [15:0]   mem_rdata;
  logic [AW:0]   len_clamp;
  logic          last_instr;
  logic          wd_hit;

  // busy_q with state IDLE only happens for the one cycle of a zero-length run.
  assign idle_free  = (state_q == S_IDLE) && !busy_q;
  assign mem_we     = wr_en && idle_free;
  assign len_clamp  = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
  assign last_instr = ({1'b0, pc_q} == (len_q - 1'b1));
  assign wd_hit     = is_wait(state_q) && (wd_q == WD_LAST);

  prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (pc_q),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cin_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cin_q   <= cin_d;
    end
  end

  // A w edge arriving on the watchdog's last cycle still counts as progress.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (idle_free && start && (len_clamp != '0)) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_KICK;
      S_KICK:    state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!cpu_w)      state_d = S_WAIT_HI;
        else if (wd_hit) state_d = S_IDLE;
      end
      S_WAIT_HI: begin
        if (cpu_w)       state_d = last_instr ? S_IDLE : S_ISSUE;
        else if (wd_hit) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    len_d  = len_q;
    wd_d   = wd_q;
    busy_d = busy_q;
    done_d = done_q;
    err_d  = err_q;
    cin_d  = cin_q;
    case (state_q)
      S_IDLE: begin
        if (busy_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (start) begin
          len_d  = len_clamp;
          pc_d   = '0;
          busy_d = 1'b1;
          done_d = 1'b0;
          err_d  = 1'b0;
        end
      end
      S_ISSUE: cin_d = mem_rdata;
      S_KICK:  wd_d  = '0;
      S_WAIT_LO: begin
        wd_d = wd_q + 1'b1;
        if (cpu_w && wd_hit) begin
          err_d  = 1'b1;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      S_WAIT_HI: begin
        wd_d = wd_q + 1'b1;
        if (cpu_w) begin
          if (last_instr) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end else if (wd_hit) begin
          err_d  = 1'b1;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // cpu_in shows the fetched word during ISSUE, then holds it while the CPU runs.
  always_comb begin
    cpu_load = 1'b0;
    cpu_s    = 1'b0;
    cpu_in   = cin_q;
    case (state_q)
      S_ISSUE: begin
        cpu_load = 1'b1;
        cpu_in   = mem_rdata;
      end
      S_KICK:  cpu_s = 1'b1;
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign pc   = pc_q;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Upstream feeder for the lab CPU.
- Holds a small program of 16-bit instructions and issues them one at a time over the CPU's in/load/s/w handshake, waiting for each instruction to complete before issuing the next.
- Replaces hand-driven in/load/s stimulus, so a whole program runs from a single start pulse.
- Includes a watchdog that flags a CPU that never returns to its wait state.

Parameters:
- DEPTH, 16: number of program words.
- AW, 4: address width, equal to clog2(DEPTH).
- TIMEOUT, 64: maximum number of cycles spent waiting on w per instruction before an error is raised.

Ports:
- clk  in  1  system clock; all logic is updated on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  program write strobe; honoured only while idle.
- wr_addr  in  AW  program write address.
- wr_data  in  16  instruction word to write.
- prog_len  in  AW+1  number of instructions to run; sampled at start.
- start  in  1  run request; honoured only while idle.
- cpu_w  in  1  CPU w output (1 = CPU waiting).
- cpu_in  out  16  drives the CPU in port.
- cpu_load  out  1  drives the CPU load port.
- cpu_s  out  1  drives the CPU s port.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until the next start or reset.
- err  out  1  watchdog fired; held until the next start or reset.
- pc  out  AW  index of the instruction currently issued.

Behaviour:
- Reset values: cpu_in=0, cpu_load=0, cpu_s=0, busy=0, done=0, err=0, pc=0, state=IDLE. Program memory is not cleared by reset.
- FSM states: IDLE, ISSUE, KICK, WAIT_LO, WAIT_HI.
- IDLE:
  - wr_en writes wr_data to mem[wr_addr].
  - start latches len = min(prog_len, DEPTH), then clears done/err, sets pc=0 and busy=1.
  - If len==0: next cycle done=1, busy=0, stay in IDLE; no cpu_load or cpu_s is issued.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle): cpu_in=mem[pc], cpu_load=1, cpu_s=0. Next state is KICK.
- KICK (1 cycle): cpu_load=0, cpu_s=1. Clear the watchdog count. Next state is WAIT_LO.
- WAIT_LO: cpu_s=0. Wait for cpu_w==0, then go to WAIT_HI.
  - This guards against a stale w=1 left over from before the CPU accepted s.
- WAIT_HI: wait for cpu_w==1.
  - If pc==len-1: go to IDLE with done=1, busy=0; pc holds the last index.
  - Otherwise pc<=pc+1 and go to ISSUE.
- Watchdog:
  - The counter increments each cycle in WAIT_LO and WAIT_HI.
  - When it reaches TIMEOUT: err=1, done=1, busy=0, cpu_s=0, go to IDLE.
- cpu_in holds its value from ISSUE until the next ISSUE; it is not changed while the CPU executes.
- Total cycles per instruction = 2 + (cycles until w falls) + (cycles until w rises).
- Ignored events:
  - start while busy is ignored.
  - wr_en while busy is ignored; memory is unchanged.
- Simultaneous start and wr_en in IDLE: the write completes and the run starts. mem[0] read in ISSUE reflects the write if wr_addr==0.
- Reset mid-run: synchronous return to the reset values on the next edge. cpu_load and cpu_s deassert immediately, and the program is retained.
- pc never wraps; len is clamped to DEPTH.

Decomposition:
- Shared package, seq_pkg:
  - FSM state encoding.
  - CPU opcode constants used by benches: MOV_IMM=5'b11010, MOV_SH=5'b11000, ADD=5'b10100, CMP=5'b10101, AND=5'b10110, MVN=5'b10111.
- One sub-module, prog_mem: DEPTH x 16 storage with synchronous write and asynchronous read, no reset.

Test Plan:
- Three-instruction run: load 16'hD005, 16'hD103, 16'hA041 with prog_len=3, pulse start.
  - Required: cpu_load pulses exactly 3 times, with cpu_s one cycle after each.
  - Required final state: CPU R0=5, R1=3, R2=8; done=1, err=0, pc=2.
- Zero-length run: prog_len=0, pulse start.
  - Required: done=1 one cycle later, busy low, no cpu_load or cpu_s pulse.
- Watchdog: a CPU model holds cpu_w=0 after s, TIMEOUT=64.
  - Required: err=1 and done=1 no later than cycle 66 after KICK, cpu_s=0, back in IDLE.
- Stale w: the model keeps cpu_w=1 for 3 cycles after s, then low for 2 cycles, then high.
  - Required: the sequencer advances only after the low-then-high sequence; the next cpu_load is not issued early.
- Reset mid-run: assert reset during WAIT_HI of instruction 2, then restart.
  - Required during reset: busy=0, pc=0, cpu_s=0, cpu_load=0.
  - Required after restart: the program runs from mem[0] and final registers match the three-instruction result.
- Ignored requests while busy: start and wr_en(addr 0, 16'hD0FF) asserted while busy.
  - Required: the run is unaffected and mem[0] still reads 16'hD005 afterwards.
